// File: rtl/button_press_classifier.sv
// Classifies debounced button activity into short, long and (optionally) double presses.
// Define DOUBLE_PRESS_EN to build the double-press states; otherwise shorts report on release.
module button_press_classifier #(
  parameter int unsigned LONG_PRESS_LIMIT = 25000000,
  parameter int unsigned DOUBLE_GAP_LIMIT = 7500000,
  parameter logic        PRESS_LEVEL      = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Debounced,
  output logic o_Pressed,
  output logic o_Short_Press,
  output logic o_Long_Press,
  output logic o_Double_Press
);

  localparam int unsigned MAX_LIMIT = (LONG_PRESS_LIMIT > DOUBLE_GAP_LIMIT) ?
                                      LONG_PRESS_LIMIT : DOUBLE_GAP_LIMIT;
  localparam int unsigned CNT_W     = $clog2(MAX_LIMIT) + 1;

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_PRESS_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

`ifdef DOUBLE_PRESS_EN
  localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(DOUBLE_GAP_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;
`endif

  state_t           r_State;
  logic [CNT_W-1:0] r_Count;
  logic             r_Prev;
  logic             r_Short_Press;
  logic             r_Long_Press;
`ifdef DOUBLE_PRESS_EN
  logic             r_Double_Press;
`endif

  logic             w_Press_Edge;
  logic             w_Release_Edge;
  logic [CNT_W-1:0] w_Count_Next;

  assign w_Press_Edge   = (i_Debounced == PRESS_LEVEL) && (r_Prev != PRESS_LEVEL);
  assign w_Release_Edge = (i_Debounced != PRESS_LEVEL) && (r_Prev == PRESS_LEVEL);
  // Saturate rather than wrap so a stuck count can never re-arm a terminal match.
  assign w_Count_Next   = (r_Count == CNT_MAX) ? r_Count : r_Count + CNT_ONE;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State        <= IDLE;
      r_Count        <= '0;
      r_Prev         <= ~PRESS_LEVEL;
      r_Short_Press  <= 1'b0;
      r_Long_Press   <= 1'b0;
`ifdef DOUBLE_PRESS_EN
      r_Double_Press <= 1'b0;
`endif
    end else begin
      r_Prev         <= i_Debounced;
      r_Short_Press  <= 1'b0;
      r_Long_Press   <= 1'b0;
`ifdef DOUBLE_PRESS_EN
      r_Double_Press <= 1'b0;
`endif
      case (r_State)
        IDLE: begin
          r_Count <= '0;
          if (w_Press_Edge) begin
            r_State <= PRESSED;
          end
        end

        PRESSED: begin
          if (w_Release_Edge) begin
            r_Count <= '0;
`ifdef DOUBLE_PRESS_EN
            r_State <= WAIT_SECOND;
`else
            r_Short_Press <= 1'b1;
            r_State       <= IDLE;
`endif
          end else if (r_Count == LONG_TERM) begin
            r_Long_Press <= 1'b1;
            r_Count      <= '0;
            r_State      <= LONG_HELD;
          end else begin
            r_Count <= w_Count_Next;
          end
        end

        LONG_HELD: begin
          r_Count <= '0;
          if (w_Release_Edge) begin
            r_State <= IDLE;
          end
        end

`ifdef DOUBLE_PRESS_EN
        WAIT_SECOND: begin
          // A press landing on the terminal gap count still counts as a double press.
          if (w_Press_Edge) begin
            r_Count <= '0;
            r_State <= SECOND_PRESSED;
          end else if (r_Count == GAP_TERM) begin
            r_Short_Press <= 1'b1;
            r_Count       <= '0;
            r_State       <= IDLE;
          end else begin
            r_Count <= w_Count_Next;
          end
        end

        SECOND_PRESSED: begin
          if (w_Release_Edge) begin
            r_Double_Press <= 1'b1;
            r_Count        <= '0;
            r_State        <= IDLE;
          end else if (r_Count == LONG_TERM) begin
            r_Double_Press <= 1'b1;
            r_Count        <= '0;
            r_State        <= LONG_HELD;
          end else begin
            r_Count <= w_Count_Next;
          end
        end
`endif

        default: begin
          r_Count <= '0;
          r_State <= IDLE;
        end
      endcase
    end
  end

  assign o_Pressed      = (r_Prev == PRESS_LEVEL);
  assign o_Short_Press  = r_Short_Press;
  assign o_Long_Press   = r_Long_Press;
`ifdef DOUBLE_PRESS_EN
  assign o_Double_Press = r_Double_Press;
`else
  assign o_Double_Press = 1'b0;
`endif

endmodule

// File: doc/button_press_classifier.md
BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

Interface
REQ-001 The block SHALL have parameter LONG_PRESS_LIMIT, default 25000000 (1 s at 25 MHz), the hold duration in clocks that makes a press long; legal range is 2 or more.
REQ-002 The block SHALL have parameter DOUBLE_GAP_LIMIT, default 7500000 (300 ms), the maximum release-to-press gap in clocks for a double press; legal range is 2 or more.
REQ-003 The block SHALL have parameter PRESS_LEVEL, default 1, the i_Debounced level that means "pressed".
REQ-004 The block SHALL have port i_Clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port i_Rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port i_Debounced, input, 1 bit: the switch level from the debounce filter, already synchronous to i_Clk.
REQ-007 The block SHALL have port o_Pressed, output, 1 bit: registered level, 1 while the button is pressed.
REQ-008 The block SHALL have port o_Short_Press, output, 1 bit: one-clock pulse for a short press.
REQ-009 The block SHALL have port o_Long_Press, output, 1 bit: one-clock pulse for a long press.
REQ-010 The block SHALL have port o_Double_Press, output, 1 bit: one-clock pulse for a double press.

Function
REQ-011 The block SHALL register i_Debounced into r_Prev every clock; a press edge is i_Debounced==PRESS_LEVEL with r_Prev!=PRESS_LEVEL, and a release edge is the reverse.
REQ-012 The state machine SHALL have exactly five states: IDLE, PRESSED, LONG_HELD, WAIT_SECOND and SECOND_PRESSED; one counter, sized by $clog2 of the larger limit plus 1, SHALL be shared by all states and cleared on every state change.
REQ-013 In IDLE, a press edge SHALL move the state to PRESSED.
REQ-014 In PRESSED, the counter SHALL increment each clock while pressed; reaching LONG_PRESS_LIMIT-1 SHALL pulse o_Long_Press and move the state to LONG_HELD.
REQ-015 In PRESSED, a release edge before the limit SHALL move the state to WAIT_SECOND (DOUBLE_PRESS_EN defined), or pulse o_Short_Press and move the state to IDLE (macro undefined).
REQ-016 In LONG_HELD, a release edge SHALL move the state to IDLE with no further pulse.
REQ-017 In WAIT_SECOND, the counter SHALL increment each clock; a press edge SHALL move the state to SECOND_PRESSED; the counter reaching DOUBLE_GAP_LIMIT-1 SHALL pulse o_Short_Press and move the state to IDLE; if both occur in the same clock, the press edge SHALL win.
REQ-018 In SECOND_PRESSED, a release edge SHALL pulse o_Double_Press and move the state to IDLE; reaching LONG_PRESS_LIMIT-1 while held SHALL pulse o_Double_Press and move the state to LONG_HELD.
REQ-019 Every pulse SHALL be registered, high for exactly one clock, and asserted in the clock after the deciding edge or count is sampled.
REQ-020 At most one of the three pulse outputs SHALL be high in any clock, and exactly one pulse SHALL be emitted per gesture.
REQ-021 o_Pressed SHALL equal r_Prev==PRESS_LEVEL, giving 1-clock latency from i_Debounced.
REQ-022 The counter SHALL never wrap; it SHALL saturate at its terminal value.

Reset
REQ-023 While i_Rst is high, the block SHALL hold state IDLE, counter 0, r_Prev=!PRESS_LEVEL and all outputs 0, regardless of the clock.
REQ-024 Reset asserted mid-gesture SHALL abort the gesture with no pulse emitted.
REQ-025 A button held through reset deassertion SHALL be seen as a press edge on the first clock after deassertion.

Configuration
REQ-026 Macro DOUBLE_PRESS_EN defined SHALL enable the WAIT_SECOND and SECOND_PRESSED states and double-press detection.
REQ-027 With DOUBLE_PRESS_EN undefined, those two states and their logic SHALL be absent, o_Double_Press SHALL be tied to 0, and short presses SHALL be reported with 1-clock latency after release.

Verification (LONG_PRESS_LIMIT=20, DOUBLE_GAP_LIMIT=10, PRESS_LEVEL=1)
REQ-028 Short press: press 5 clocks, release, then idle 15 clocks -> o_Short_Press pulses once, 10 clocks after the release is sampled (macro defined) or 1 clock after it (undefined).
REQ-029 Long press: hold 30 clocks -> o_Long_Press pulses once at hold count 20, and no pulse occurs on release.
REQ-030 Double press: press 4, release 3, press 4, release -> o_Double_Press pulses once after the second release, and o_Short_Press stays 0.
REQ-031 Gap boundary: second press arriving exactly as the gap counter reaches 9 -> press wins and o_Double_Press follows; a second press 1 clock later -> o_Short_Press, then a new gesture begins.
REQ-032 Reset mid-press: assert i_Rst at hold count 15, release it at count 18 with the button still held -> no pulse during reset, o_Pressed=0 during reset, and o_Long_Press pulses 20 clocks after reset deassertion.
